cnn_layer_accel_prefetch_buffer_pp: RTL and testbench



---
 rtl/cnn_layer_accel_prefetch_buffer_pp.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_cnn_layer_accel_prefetch_buffer_pp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_prefetch_buffer_pp.sv
// cnn_layer_accel_prefetch_buffer_pp
//   Ping-pong row prefetch buffer for a CNN layer accelerator. Input pixels
//   arrive in raster order and fill one of two row banks. The reader expands
//   each stored row into the output image, adding a zero border of cfg_pad
//   pixels. When built with the upsample option it can also apply a 2x
//   nearest-neighbour upsample before the border is added.
//
//   Optional feature macro: CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
//     Defined   : cfg_upsample selects 2x column replication and row repetition.
//     Undefined : cfg_upsample is ignored and no replication logic is built.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start                      job start pulse; config sampled on the same cycle
//   cfg_num_cols/cfg_num_rows  input image dimensions (CW bits each)
//   cfg_pad                    zero-border width in pixels
//   cfg_upsample               2x nearest-neighbour upsample request
//   wr_valid/wr_data/wr_ready  raster-order input pixel stream
//   rd_valid/rd_data/rd_ready  expanded output pixel stream
//   rd_last_col/rd_last_row    rd_data is in the last output column / row
//   busy/done/cfg_err          job active / completion pulse / rejected config
module cnn_layer_accel_prefetch_buffer_pp #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_MAX_COLS    = 512,
  parameter int C_MAX_PAD     = 3,
  localparam int CW           = $clog2(C_MAX_COLS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CW-1:0]            cfg_num_cols,
  input  logic [CW-1:0]            cfg_num_rows,
  input  logic [1:0]               cfg_pad,
  input  logic                     cfg_upsample,
  input  logic                     wr_valid,
  input  logic [C_PIXEL_WIDTH-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [C_PIXEL_WIDTH-1:0] rd_data,
  input  logic                     rd_ready,
  output logic                     rd_last_col,
  output logic                     rd_last_row,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int AW = (C_MAX_COLS > 1) ? $clog2(C_MAX_COLS) : 1;
  // Output coordinates must reach 2*max_cols + 2*max_pad.
  localparam int OW = $clog2(2 * (2 ** CW) + 2 * C_MAX_PAD + 1);
  localparam logic [CW-1:0] LP_MAX_COLS = CW'(C_MAX_COLS);
  localparam logic [2:0]    LP_MAX_PAD  = (C_MAX_PAD >= 3) ? 3'd3 : 3'(C_MAX_PAD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  // configuration
  logic                w_cfg_up, w_cfg_legal, w_start_ok;
  logic [OW-1:0]       w_cfg_ucols, w_cfg_urows, w_cfg_pad;
  logic [CW-1:0]       r_cols, r_rows;
  logic [1:0]          r_pad;
  logic [OW-1:0]       r_oc_ihi, r_oc_ilast, r_oc_last, r_or_ihi, r_or_last;
  logic                r_cfg_err;

  // banks and write side
  logic [C_PIXEL_WIDTH-1:0] r_mem0 [C_MAX_COLS];
  logic [C_PIXEL_WIDTH-1:0] r_mem1 [C_MAX_COLS];
  logic [1:0]          r_full, w_full_nxt;
  logic                r_wbank;
  logic [CW-1:0]       r_wcol, r_wrows;
  logic [AW-1:0]       w_waddr;
  logic                w_wr_ready, w_wr_fire, w_wr_row_end;

  // reader
  logic                r_rbank, r_issue_done;
  logic [OW-1:0]       r_orow, r_ocol, w_pad_ow, w_icol;
  logic [AW-1:0]       w_raddr;
  logic                w_border, w_issue, w_row_release, w_rep_last, w_up;

  // read pipeline: bank read stage + output register
  logic                     r_s1_v, r_s1_zero, r_s1_lc, r_s1_lr;
  logic [C_PIXEL_WIDTH-1:0] r_s1_rdata, w_s1_data;
  logic                     r_o_v, r_o_lc, r_o_lr;
  logic [C_PIXEL_WIDTH-1:0] r_o_d;
  logic                     w_o_load, w_s1_free, w_final_hs;

`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
  logic r_up, r_rrep;
  assign w_cfg_up   = cfg_upsample;
  assign w_up       = r_up;
  // An input row is used twice when upsampling; release after the second pass.
  assign w_rep_last = !r_up | r_rrep;
  assign w_raddr    = AW'(w_icol >> r_up);
`else
  logic w_unused_upsample;
  assign w_unused_upsample = cfg_upsample;
  assign w_cfg_up   = 1'b0;
  assign w_up       = 1'b0;
  assign w_rep_last = 1'b1;
  assign w_raddr    = AW'(w_icol);
`endif

  // ---------------- configuration ----------------
  assign w_cfg_legal = (cfg_num_cols != '0) && (cfg_num_cols <= LP_MAX_COLS) &&
                       (cfg_num_rows != '0) && ({1'b0, cfg_pad} <= LP_MAX_PAD);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_legal;
  assign w_cfg_ucols = OW'(cfg_num_cols) << w_cfg_up;
  assign w_cfg_urows = OW'(cfg_num_rows) << w_cfg_up;
  assign w_cfg_pad   = OW'(cfg_pad);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cols     <= '0;
      r_rows     <= '0;
      r_pad      <= '0;
      r_oc_ihi   <= '0;
      r_oc_ilast <= '0;
      r_oc_last  <= '0;
      r_or_ihi   <= '0;
      r_or_last  <= '0;
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
      r_up       <= 1'b0;
`endif
    end else if (w_start_ok) begin
      r_cols     <= cfg_num_cols;
      r_rows     <= cfg_num_rows;
      r_pad      <= cfg_pad;
      // Precomputed border thresholds keep the per-pixel compare shallow.
      r_oc_ihi   <= w_cfg_ucols + w_cfg_pad;
      r_oc_ilast <= w_cfg_ucols + w_cfg_pad - OW'(1);
      r_oc_last  <= w_cfg_ucols + (w_cfg_pad << 1) - OW'(1);
      r_or_ihi   <= w_cfg_urows + w_cfg_pad;
      r_or_last  <= w_cfg_urows + (w_cfg_pad << 1) - OW'(1);
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
      r_up       <= w_cfg_up;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_cfg_err <= 1'b0;
    else        r_cfg_err <= (r_state == S_IDLE) && start && !w_cfg_legal;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_final_hs = r_o_v && rd_ready && r_o_lc && r_o_lr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_final_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    w_wr_ready = 1'b0;
    case (r_state)
      S_RUN: begin
        busy       = 1'b1;
        w_wr_ready = !r_full[r_wbank] && (r_wrows < r_rows);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- write side ----------------
  assign w_wr_fire    = wr_valid && w_wr_ready;
  assign w_wr_row_end = (r_wcol == r_cols - CW'(1));
  assign w_waddr      = r_wcol[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      if (r_wbank) r_mem1[w_waddr] <= wr_data;
      else         r_mem0[w_waddr] <= wr_data;
    end
  end

  // Release is applied after set, so it wins if both hit the same bank.
  always_comb begin
    w_full_nxt = r_full;
    for (int unsigned b = 0; b < 2; b++) begin
      if (w_wr_fire && w_wr_row_end && (r_wbank == 1'(b))) w_full_nxt[b] = 1'b1;
      if (w_row_release && (r_rbank == 1'(b)))             w_full_nxt[b] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) begin
      r_full  <= '0;
      r_wbank <= 1'b0;
      r_wcol  <= '0;
      r_wrows <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        if (w_wr_row_end) begin
          r_wcol  <= '0;
          r_wbank <= ~r_wbank;
          r_wrows <= r_wrows + CW'(1);
        end else begin
          r_wcol <= r_wcol + CW'(1);
        end
      end
    end
  end

  // ---------------- reader ----------------
  assign w_pad_ow  = OW'(r_pad);
  assign w_icol    = r_ocol - w_pad_ow;
  assign w_border  = (r_orow < w_pad_ow) || (r_orow >= r_or_ihi) ||
                     (r_ocol < w_pad_ow) || (r_ocol >= r_oc_ihi);
  assign w_o_load  = !r_o_v || rd_ready;
  assign w_s1_free = !r_s1_v || w_o_load;
  // Border pixels never touch a bank, so top padding streams before any input.
  assign w_issue   = (r_state == S_RUN) && !r_issue_done && w_s1_free &&
                     (w_border || r_full[r_rbank]);
  assign w_row_release = w_issue && !w_border && (r_ocol == r_oc_ilast) && w_rep_last;

  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) begin
      r_rbank      <= 1'b0;
      r_orow       <= '0;
      r_ocol       <= '0;
      r_issue_done <= 1'b0;
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
      r_rrep       <= 1'b0;
`endif
    end else if (w_issue) begin
      if (w_row_release) r_rbank <= ~r_rbank;
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
      if (!w_border && (r_ocol == r_oc_ilast)) r_rrep <= r_up && !r_rrep;
`endif
      if (r_ocol == r_oc_last) begin
        r_ocol <= '0;
        if (r_orow == r_or_last) r_issue_done <= 1'b1;
        else                     r_orow       <= r_orow + OW'(1);
      end else begin
        r_ocol <= r_ocol + OW'(1);
      end
    end
  end

  // Bank read; data is captured on issue, so the bank may be released the same cycle.
  always_ff @(posedge clk) begin
    if (w_issue && !w_border) begin
      r_s1_rdata <= r_rbank ? r_mem1[w_raddr] : r_mem0[w_raddr];
    end
  end

  assign w_s1_data = r_s1_zero ? '0 : r_s1_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_lc   <= 1'b0;
      r_s1_lr   <= 1'b0;
      r_o_v     <= 1'b0;
      r_o_d     <= '0;
      r_o_lc    <= 1'b0;
      r_o_lr    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_s1_v    <= 1'b1;
        r_s1_zero <= w_border;
        r_s1_lc   <= (r_ocol == r_oc_last);
        r_s1_lr   <= (r_orow == r_or_last);
      end else if (w_o_load) begin
        r_s1_v <= 1'b0;
      end
      if (w_o_load) begin
        r_o_v <= r_s1_v;
        if (r_s1_v) begin
          r_o_d  <= w_s1_data;
          r_o_lc <= r_s1_lc;
          r_o_lr <= r_s1_lr;
        end
      end
    end
  end

  assign wr_ready    = w_wr_ready;
  assign rd_valid    = r_o_v;
  assign rd_data     = r_o_d;
  assign rd_last_col = r_o_lc;
  assign rd_last_row = r_o_lr;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_buffer_pp.sv
module tb_cnn_layer_accel_prefetch_buffer_pp;
  localparam int W  = 16;
  localparam int MC = 16;
  localparam int MP = 3;
  localparam int CW = $clog2(MC) + 1;

  logic          clk = 1'b0;
  logic          rst_n, start, cfg_upsample;
  logic [CW-1:0] cfg_num_cols, cfg_num_rows;
  logic [1:0]    cfg_pad;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [W-1:0]  wr_data, rd_data;
  logic          rd_last_col, rd_last_row, busy, done, cfg_err;

  always #5 clk = ~clk;

  cnn_layer_accel_prefetch_buffer_pp #(
    .C_PIXEL_WIDTH(W),
    .C_MAX_COLS(MC),
    .C_MAX_PAD(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_cols(cfg_num_cols), .cfg_num_rows(cfg_num_rows),
    .cfg_pad(cfg_pad), .cfg_upsample(cfg_upsample),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .rd_last_col(rd_last_col), .rd_last_row(rd_last_row),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // mode: 0 rd_ready=1, 1 rd_ready toggles, 2 rd_ready=0 for 40 cycles,
  //       3 no input for 20 cycles
  typedef struct {
    int cols; int rows; int pad; bit up; int mode; bit exp_err; int exp_n;
  } job_t;
  typedef struct { logic [W-1:0] d; logic lc; logic lr; } px_t;

  px_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference expansion of the input image (pixel value = raster index + 1).
  task automatic build_expected(input job_t j);
    int u, oc, orr, r, c;
    bit up_eff;
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
    up_eff = j.up;
`else
    up_eff = 1'b0;
`endif
    u   = up_eff ? 2 : 1;
    oc  = u * j.cols + 2 * j.pad;
    orr = u * j.rows + 2 * j.pad;
    for (int y = 0; y < orr; y++) begin
      for (int x = 0; x < oc; x++) begin
        px_t p;
        if (y < j.pad || y >= orr - j.pad || x < j.pad || x >= oc - j.pad) begin
          p.d = '0;
        end else begin
          r   = (y - j.pad) / u;
          c   = (x - j.pad) / u;
          p.d = W'(r * j.cols + c + 1);
        end
        p.lc = (x == oc - 1);
        p.lr = (y == orr - 1);
        sb.push_back(p);
      end
    end
  endtask

  task automatic start_job(input job_t j);
    @(negedge clk);
    cfg_num_cols = CW'(j.cols);
    cfg_num_rows = CW'(j.rows);
    cfg_pad      = 2'(j.pad);
    cfg_upsample = j.up;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic run_job(input job_t j, input string tag);
    int idx, popped, cyc, total_in, row0_cyc, first_rv;
    bit hold;
    logic [W-1:0] hold_d;
    logic hold_lc, hold_lr;
    start_job(j);
    #1;
    check({tag, "_cfg_err"}, cfg_err, j.exp_err);
    check({tag, "_busy"}, busy, !j.exp_err);
    if (j.exp_err) begin
      @(negedge clk); #1;
      check({tag, "_cfg_err_pulse"}, cfg_err, 0);
      check({tag, "_busy_idle"}, busy, 0);
      return;
    end
    build_expected(j);
    total_in = j.cols * j.rows;
    idx = 0; popped = 0; cyc = 0; row0_cyc = -1; first_rv = -1; hold = 1'b0;
    hold_d = '0; hold_lc = 1'b0; hold_lr = 1'b0;
    while (sb.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      wr_valid = (idx < total_in) && !(j.mode == 3 && cyc < 20);
      wr_data  = W'(idx + 1);
      if (j.mode == 1)                  rd_ready = (cyc % 2) == 1;
      else if (j.mode == 2 && cyc < 40) rd_ready = 1'b0;
      else                              rd_ready = 1'b1;
      #1;
      if (hold) begin
        check({tag, "_hold"}, {rd_valid, rd_data, rd_last_col, rd_last_row},
              {1'b1, hold_d, hold_lc, hold_lr});
      end
      if (j.mode == 2 && cyc == 39) begin
        check({tag, "_wr_accepted_stalled"}, idx, 16);
        check({tag, "_wr_ready_stalled"}, wr_ready, 0);
      end
      if (j.mode == 3 && cyc == 19) begin
        check({tag, "_toppad_streams"}, popped >= 5, 1);
        check({tag, "_no_input_yet"}, idx, 0);
      end
      if (wr_valid && wr_ready) begin
        idx++;
        if (idx == j.cols && row0_cyc < 0) row0_cyc = cyc;
        if (j.mode == 2 && idx == 17) check({tag, "_resume_after_release"}, popped >= 6, 1);
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        px_t e;
        e = sb.pop_front();
        if ({rd_data, rd_last_col, rd_last_row} != {e.d, e.lc, e.lr}) begin
          n_chk++;
          $display("FAIL %s_px%0d: got d=%0d lc=%0d lr=%0d, expected d=%0d lc=%0d lr=%0d",
                   tag, popped, rd_data, rd_last_col, rd_last_row, e.d, e.lc, e.lr);
        end else begin
          n_chk++;
          n_pass++;
        end
        popped++;
      end
      hold    = rd_valid && !rd_ready;
      hold_d  = rd_data;
      hold_lc = rd_last_col;
      hold_lr = rd_last_row;
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    sb.delete();
    check({tag, "_out_count"}, popped, j.exp_n);
    check({tag, "_in_count"}, idx, total_in);
    if (j.mode == 0 && j.pad == 0 && !j.up)
      check({tag, "_first_latency"}, first_rv - row0_cyc, 3);
    @(negedge clk); #1;
    check({tag, "_done"}, {done, busy, rd_valid}, 3'b100);
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
  endtask

  job_t jobs[11];

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_upsample = 1'b0;
    cfg_num_cols = '0; cfg_num_rows = '0; cfg_pad = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;

    jobs[0]  = '{cols:4,  rows:3, pad:0, up:0, mode:0, exp_err:0, exp_n:12};
    jobs[1]  = '{cols:3,  rows:2, pad:1, up:0, mode:0, exp_err:0, exp_n:20};
    jobs[2]  = '{cols:4,  rows:3, pad:0, up:0, mode:1, exp_err:0, exp_n:12};
`ifdef CNN_LAYER_ACCEL_PFB_UPSAMPLE_EN
    jobs[3]  = '{cols:2,  rows:2, pad:0, up:1, mode:0, exp_err:0, exp_n:16};
    jobs[10] = '{cols:1,  rows:1, pad:3, up:1, mode:1, exp_err:0, exp_n:64};
`else
    jobs[3]  = '{cols:2,  rows:2, pad:0, up:1, mode:0, exp_err:0, exp_n:4};
    jobs[10] = '{cols:1,  rows:1, pad:3, up:1, mode:1, exp_err:0, exp_n:49};
`endif
    jobs[4]  = '{cols:8,  rows:4, pad:0, up:0, mode:2, exp_err:0, exp_n:32};
    jobs[5]  = '{cols:3,  rows:2, pad:1, up:0, mode:3, exp_err:0, exp_n:20};
    jobs[6]  = '{cols:16, rows:2, pad:3, up:0, mode:1, exp_err:0, exp_n:176};
    jobs[7]  = '{cols:0,  rows:3, pad:0, up:0, mode:0, exp_err:1, exp_n:0};
    jobs[8]  = '{cols:17, rows:3, pad:0, up:0, mode:0, exp_err:1, exp_n:0};
    jobs[9]  = '{cols:4,  rows:0, pad:1, up:0, mode:0, exp_err:1, exp_n:0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_outputs", {busy, done, cfg_err, rd_valid, wr_ready}, 5'b00000);

    for (int i = 0; i < 11; i++) run_job(jobs[i], $sformatf("job%0d", i));

    // Reset in the middle of a job, then the same job must run cleanly.
    start_job(jobs[0]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = W'(k + 1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    #1;
    check("midjob_reset", {busy, rd_valid, wr_ready, done}, 4'b0000);
    run_job(jobs[0], "after_reset");
    run_job(jobs[7], "after_reset_err");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
